// File: rtl/mavg_pkg.sv
// Shared types and helpers for the multi-channel moving-average filter.
package mavg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        UPDATE = 2'd2,
        OUTPUT = 2'd3
    } mavg_state_t;

    // Running sum needs room for a full window of maximum-valued samples.
    function automatic int sum_width(input int data_width, input int max_log2_taps);
        return data_width + max_log2_taps;
    endfunction

    function automatic int clamp_log2_taps(input int value, input int max_log2_taps);
        return (value > max_log2_taps) ? max_log2_taps : value;
    endfunction

endpackage

// File: rtl/mavg_sample_ram.sv
// Sample history store: one write port, one synchronous read port, no reset.
module mavg_sample_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ENTRIES    = 64,
    parameter int ADDR_W     = 6
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/multichannel_moving_average.sv
// Time-multiplexed per-channel moving average with a runtime power-of-two window.
// Define MAVG_ROUNDING_EN for round-half-up results instead of truncation.
module multichannel_moving_average
    import mavg_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_CHANNELS  = 4,
    parameter int MAX_LOG2_TAPS = 4,
    parameter int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int TAPS_W        = (MAX_LOG2_TAPS > 0) ? $clog2(MAX_LOG2_TAPS + 1) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [TAPS_W-1:0]     log2_taps,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_W-1:0]       in_channel,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_W-1:0]       out_channel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam int DEPTH  = 2 ** MAX_LOG2_TAPS;
    localparam int SUM_W  = sum_width(DATA_WIDTH, MAX_LOG2_TAPS);
    localparam int FILL_W = MAX_LOG2_TAPS + 1;
    localparam int IDX_W  = MAX_LOG2_TAPS;

    mavg_state_t state, state_next;

    logic                  ready_ok;
    logic [TAPS_W-1:0]     taps_prev;
    logic [TAPS_W-1:0]     taps_eff;
    logic                  flush;
    logic                  in_fire;
    logic                  ch_ok;
    logic                  ram_we;

    logic [CH_W-1:0]       lat_ch;
    logic [DATA_WIDTH-1:0] lat_data;

    logic [IDX_W-1:0]      wr_ptr [NUM_CHANNELS];
    logic [FILL_W-1:0]     fill   [NUM_CHANNELS];
    logic [SUM_W-1:0]      sum    [NUM_CHANNELS];

    logic [FILL_W-1:0]     window;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] oldest;
    logic [SUM_W-1:0]      sum_new;
    logic [FILL_W-1:0]     fill_new;
    logic [DATA_WIDTH-1:0] avg;

    assign taps_eff  = TAPS_W'(clamp_log2_taps(int'(log2_taps), MAX_LOG2_TAPS));
    assign flush     = clear || (log2_taps != taps_prev);
    assign window    = FILL_W'(1) << taps_eff;
    assign in_ready  = (state == IDLE) && enable && ready_ok;
    assign in_fire   = in_valid && in_ready;
    assign ch_ok     = (int'(in_channel) < NUM_CHANNELS);
    assign out_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);
    assign ram_we    = (state == UPDATE) && !flush;

    // The sample leaving the window sits N writes behind the write pointer.
    assign rd_idx   = wr_ptr[lat_ch] - window[IDX_W-1:0];
    assign oldest   = (fill[lat_ch] >= window) ? ram_q : '0;
    assign sum_new  = sum[lat_ch] + SUM_W'(lat_data) - SUM_W'(oldest);
    assign fill_new = (fill[lat_ch] == FILL_W'(DEPTH)) ? fill[lat_ch] : fill[lat_ch] + 1'b1;

`ifdef MAVG_ROUNDING_EN
    localparam logic [SUM_W:0] ROUND_ONE = 1;
    logic [SUM_W:0] round_add;
    logic [SUM_W:0] rounded;

    always_comb begin
        round_add = '0;
        if (taps_eff != '0) begin
            round_add = ROUND_ONE << (taps_eff - 1'b1);
        end
        rounded = ({1'b0, sum_new} + round_add) >> taps_eff;
        avg     = (|rounded[SUM_W:DATA_WIDTH]) ? '1 : rounded[DATA_WIDTH-1:0];
    end
`else
    assign avg = DATA_WIDTH'(sum_new >> taps_eff);
`endif

    mavg_sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (NUM_CHANNELS * DEPTH),
        .ADDR_W     (CH_W + IDX_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_we),
        .wr_addr ({lat_ch, wr_ptr[lat_ch]}),
        .wr_data (lat_data),
        .rd_addr ({lat_ch, rd_idx}),
        .rd_data (ram_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Out-of-range channels complete the handshake but never leave IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_fire && ch_ok) state_next = READ;
            READ:    state_next = UPDATE;
            UPDATE:  state_next = (fill_new >= window) ? OUTPUT : IDLE;
            OUTPUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        ready_ok  <= !reset;
        taps_prev <= log2_taps;
        if (reset || flush) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                fill[c]   <= '0;
                sum[c]    <= '0;
            end
        end else if (state == UPDATE) begin
            wr_ptr[lat_ch] <= wr_ptr[lat_ch] + 1'b1;
            fill[lat_ch]   <= fill_new;
            sum[lat_ch]    <= sum_new;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_ch      <= '0;
            lat_data    <= '0;
            out_channel <= '0;
            out_data    <= '0;
        end else begin
            if (in_fire && ch_ok && !flush) begin
                lat_ch   <= in_channel;
                lat_data <= in_data;
            end
            if (state == UPDATE && !flush) begin
                out_channel <= lat_ch;
                out_data    <= avg;
            end
        end
    end

endmodule

// File: tb/tb_multichannel_moving_average.sv
// Self-checking bench for multichannel_moving_average (five channels so tag 7 is out of range).
module tb_multichannel_moving_average;

    localparam int DW  = 16;
    localparam int NCH = 5;
    localparam int ML2 = 4;
    localparam int CHW = 3;
    localparam int TW  = 3;
`ifdef MAVG_ROUNDING_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic           enable;
    logic           clear;
    logic [TW-1:0]  log2_taps;
    logic           in_valid;
    logic           in_ready;
    logic [CHW-1:0] in_channel;
    logic [DW-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic [CHW-1:0] out_channel;
    logic [DW-1:0]  out_data;
    logic           busy;

    int passed = 0;
    int total  = 0;
    int cur_taps;
    int unsigned hist [NCH][$];

    typedef struct {
        int          ch;
        int unsigned data;
        int          taps;
        bit          exp_v;
        int unsigned exp_d;
    } vec_t;
    vec_t tbl[$];

    always #5 clock = ~clock;

    multichannel_moving_average #(
        .DATA_WIDTH    (DW),
        .NUM_CHANNELS  (NCH),
        .MAX_LOG2_TAPS (ML2),
        .CH_W          (CHW),
        .TAPS_W        (TW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .log2_taps   (log2_taps),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_channel  (in_channel),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_channel (out_channel),
        .out_data    (out_data),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic void model_flush();
        for (int c = 0; c < NCH; c++) hist[c].delete();
    endfunction

    // Average of the most recent N samples seen on a channel since the last flush.
    function automatic void model_push(input int ch, input int unsigned data, input int taps,
                                       output bit v, output int unsigned d);
        int l;
        int n;
        longint unsigned s;
        l = (taps > ML2) ? ML2 : taps;
        n = 1 << l;
        v = 1'b0;
        d = 0;
        s = 0;
        if (ch >= NCH) return;
        hist[ch].push_back(data);
        if (hist[ch].size() > (1 << ML2)) void'(hist[ch].pop_front());
        if (hist[ch].size() < n) return;
        for (int k = hist[ch].size() - n; k < hist[ch].size(); k++) s += 64'(hist[ch][k]);
        if (ROUND && l > 0) s += 64'(1) << (l - 1);
        s = s >> l;
        if (s > 64'hFFFF) s = 64'hFFFF;
        v = 1'b1;
        d = 32'(s);
    endfunction

    function automatic void add_vec(input int ch, input int unsigned data, input int taps,
                                    input bit v, input int unsigned d);
        vec_t e;
        e.ch = ch; e.data = data; e.taps = taps; e.exp_v = v; e.exp_d = d;
        tbl.push_back(e);
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        model_flush();
    endtask

    task automatic set_taps(input int l);
        if (l == cur_taps) begin
            do_clear();
        end else begin
            log2_taps = TW'(l);
            @(negedge clock);
            @(negedge clock);
            model_flush();
        end
        cur_taps = l;
    endtask

    task automatic applyStimulus(input int ch, input int unsigned data);
        int waitc;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        if (in_ready !== 1'b1) check("accept_timeout", 64'(in_ready), 64'(1));
        in_valid   = 1'b1;
        in_channel = CHW'(ch);
        in_data    = DW'(data);
        @(negedge clock);
        in_valid   = 1'b0;
    endtask

    // Handshake, verify 3-cycle latency, optionally hold out_ready low, then acknowledge.
    task automatic checkOutput(input int ch, input int unsigned data, input bit exp_v,
                               input int unsigned exp_d, input int hold, input string name);
        applyStimulus(ch, data);
        check({name, "_lat1"}, 64'({out_valid, busy}), 64'({1'b0, ch < NCH}));
        @(negedge clock);
        check({name, "_lat2"}, 64'(out_valid), 64'(0));
        @(negedge clock);
        check({name, "_valid"}, 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
            check({name, "_data"}, 64'(out_data), 64'(exp_d));
            check({name, "_chan"}, 64'(out_channel), 64'(ch));
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                check({name, "_hold"}, 64'({out_valid, in_ready, out_channel, out_data}),
                      64'({1'b1, 1'b0, CHW'(ch), DW'(exp_d)}));
            end
            out_ready = 1'b1;
            @(negedge clock);
            out_ready = 1'b0;
            check({name, "_ack"}, 64'(out_valid), 64'(0));
        end else if (out_valid) begin
            out_ready = 1'b1;
            @(negedge clock);
            out_ready = 1'b0;
        end
    endtask

    task automatic reach_output(input int ch, input int unsigned data, input string name);
        applyStimulus(ch, data);
        @(negedge clock);
        @(negedge clock);
        check({name, "_out"}, 64'({out_valid, out_data}), 64'({1'b1, DW'(data)}));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          v;
        int unsigned d;
        int          ch;
        int unsigned data;

        reset = 1'b1; enable = 1'b1; clear = 1'b0; log2_taps = TW'(2);
        in_valid = 1'b0; in_channel = '0; in_data = '0; out_ready = 1'b0;
        cur_taps = 2;
        model_flush();

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_in_ready_low", 64'(in_ready), 64'(0));
        check("rst_outputs", 64'({out_valid, busy, out_channel, out_data}), 64'(0));
        @(negedge clock);
        check("rst_in_ready_follows", 64'(in_ready), 64'(1));

        add_vec(0, 4, 2, 0, 0);   add_vec(0, 8, 2, 0, 0);   add_vec(0, 12, 2, 0, 0);
        add_vec(0, 16, 2, 1, 10); add_vec(0, 20, 2, 1, 14);
        add_vec(7, 1000, 2, 0, 0); add_vec(0, 24, 2, 1, 18);
        add_vec(0, 100, 1, 0, 0); add_vec(1, 1, 1, 0, 0);
        add_vec(0, 200, 1, 1, 150); add_vec(1, 3, 1, 1, 2);
        add_vec(2, 1234, 0, 1, 1234); add_vec(3, 65535, 0, 1, 65535); add_vec(4, 7, 0, 1, 7);
        add_vec(1, 1, 2, 0, 0); add_vec(1, 2, 2, 0, 0); add_vec(1, 0, 2, 0, 0);
        add_vec(1, 0, 2, 1, ROUND ? 1 : 0);
        for (int i = 0; i < 16; i++) add_vec(0, 65535, 4, i == 15, (i == 15) ? 65535 : 0);
        for (int i = 0; i < 16; i++) add_vec(3, 1000, 6, i == 15, (i == 15) ? 1000 : 0);

        foreach (tbl[i]) begin
            if (tbl[i].taps != cur_taps) set_taps(tbl[i].taps);
            checkOutput(tbl[i].ch, tbl[i].data, tbl[i].exp_v, tbl[i].exp_d, i % 3,
                        $sformatf("vec%0d", i));
        end

        set_taps(2);
        checkOutput(0, 5, 0, 0, 0, "clr_pre0");
        checkOutput(0, 9, 0, 0, 0, "clr_pre1");
        do_clear();
        for (int i = 0; i < 3; i++) checkOutput(0, 1, 0, 0, 0, $sformatf("clr_post%0d", i));
        checkOutput(0, 1, 1, 1, 0, "clr_post3");
        set_taps(3);
        for (int i = 0; i < 7; i++) checkOutput(0, 3, 0, 0, 0, $sformatf("tchg%0d", i));
        checkOutput(0, 3, 1, 3, 0, "tchg7");

        set_taps(0);
        checkOutput(2, 16'h55AA, 1, 16'h55AA, 10, "hold");

        enable = 1'b0;
        @(negedge clock);
        check("enable_low_ready", 64'(in_ready), 64'(0));
        enable = 1'b1;
        applyStimulus(1, 321);
        enable = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("enable_fall_out", 64'({out_valid, out_data}), 64'({1'b1, DW'(321)}));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("enable_fall_done", 64'({out_valid, in_ready}), 64'(0));
        enable = 1'b1;
        @(negedge clock);

        set_taps(1);
        in_valid = 1'b1; in_channel = CHW'(0); in_data = DW'(40); clear = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; clear = 1'b0;
        model_flush();
        check("clr_hs_busy", 64'(busy), 64'(0));
        checkOutput(0, 50, 0, 0, 0, "clr_hs_next");
        checkOutput(0, 60, 1, 55, 0, "clr_hs_pair");

        set_taps(0);
        reach_output(3, 77, "clr_pend");
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        model_flush();
        check("clr_pend_drop", 64'({out_valid, busy}), 64'(0));

        reach_output(1, 9, "rst_pend");
        reset = 1'b1;
        @(negedge clock);
        check("rst_pend_drop", 64'({out_valid, busy, out_channel, out_data}), 64'(0));
        reset = 1'b0;
        check("rst_pend_ready_low", 64'(in_ready), 64'(0));
        @(negedge clock);
        check("rst_pend_ready_high", 64'(in_ready), 64'(1));
        model_flush();

        for (int seg = 0; seg < 5; seg++) begin
            set_taps(int'($urandom_range(0, 7)));
            for (int k = 0; k < 40; k++) begin
                ch   = ($urandom_range(0, 7) == 0) ? 7 : int'($urandom_range(0, NCH - 1));
                data = $urandom_range(0, 65535);
                model_push(ch, data, cur_taps, v, d);
                checkOutput(ch, data, v, d, int'($urandom_range(0, 2)),
                            $sformatf("rnd%0d_%0d", seg, k));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
